// File: rtl/ch_bram_responder_pkg.sv
// ---------------------------------------------------------------------------
// ch_bram_responder_pkg
// Shared definitions for the BRAM-backed channel responder:
//   - channel address width and the font/screen region base addresses
//   - FSM state encoding (the values are visible on test_state)
//   - max3() helper used to size the latency down-counter
// ---------------------------------------------------------------------------
package ch_bram_responder_pkg;

    localparam int CH_AW = 25;

    localparam logic [CH_AW-1:0] FONT_ADDR_START   = 25'h0000000;
    localparam logic [CH_AW-1:0] SCREEN_ADDR_START = 25'h0002000;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RD_WAIT = 2'd1,
        ST_WR_WAIT = 2'd2,
        ST_REFRESH = 2'd3
    } state_t;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/ch_bram_responder_bram_sp.sv
// ---------------------------------------------------------------------------
// ch_bram_responder_bram_sp
// Single-port (2**AW) x DW block RAM with a one-cycle registered read.
// Ports:
//   i_clk   clock
//   i_we    write enable; i_din is stored at i_addr on the rising edge
//   i_addr  word address (shared by read and write)
//   i_din   write data
//   o_q     registered read data: contents of i_addr as of the last edge
// ---------------------------------------------------------------------------
module ch_bram_responder_bram_sp #(
    parameter int AW = 14,
    parameter int DW = 8
) (
    input  logic          i_clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_addr,
    input  logic [DW-1:0] i_din,
    output logic [DW-1:0] o_q
);

    logic [DW-1:0] r_mem [0:(2**AW)-1];

    // NOTE: storage arrays carry no reset so they map onto block RAM;
    // contents survive a channel reset, which the responder relies on.
    // NOTE: sequential state is always updated with non-blocking <= so every
    // register samples the pre-edge value of every other register.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_din;
        end
        o_q <= r_mem[i_addr];
    end

endmodule

// File: rtl/ch_bram_responder.sv
// ---------------------------------------------------------------------------
// ch_bram_responder
// Responder for the sdram-style channel, backed by on-chip BRAM. Reproduces
// the controller's edge-triggered request handshake and busy timing.
// Ports:
//   clk_sys     single clock
//   reset       synchronous, active-high
//   ch_addr     byte address (low MEM_AW bits used), latched at accept
//   ch_wr       write request, rising-edge triggered
//   ch_din      write data, latched at accept
//   ch_rd       read request, rising-edge triggered
//   ch_dout     read data, held until the next read completes
//   ch_busy     combinational busy: not idle, new edge, or request pending
//   refresh     level request for a refresh slot
//   ch_err      sticky collision/overrun flag, cleared only by reset
//   test_state  current FSM state
// ---------------------------------------------------------------------------
module ch_bram_responder
    import ch_bram_responder_pkg::*;
#(
    parameter int MEM_AW         = 14,
    parameter int DATA_W         = 8,
    parameter int RD_LATENCY     = 4,
    parameter int WR_LATENCY     = 3,
    parameter int REFRESH_CYCLES = 6
) (
    input  logic              clk_sys,
    input  logic              reset,
    input  logic [CH_AW-1:0]  ch_addr,
    input  logic              ch_wr,
    input  logic [DATA_W-1:0] ch_din,
    input  logic              ch_rd,
    output logic [DATA_W-1:0] ch_dout,
    output logic              ch_busy,
    input  logic              refresh,
    output logic              ch_err,
    output logic [1:0]        test_state
);

    localparam int MAX_LAT = max3(RD_LATENCY, WR_LATENCY, REFRESH_CYCLES);
    localparam int CNT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;

    localparam logic [CNT_W-1:0] RD_CNT  = CNT_W'(RD_LATENCY - 1);
    localparam logic [CNT_W-1:0] WR_CNT  = CNT_W'(WR_LATENCY - 1);
    localparam logic [CNT_W-1:0] REF_CNT = CNT_W'(REFRESH_CYCLES - 1);

    state_t              r_state;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_rd_q;
    logic                r_wr_q;
    logic                r_pend_vld;
    logic                r_pend_wr;
    logic [MEM_AW-1:0]   r_pend_addr;
    logic [DATA_W-1:0]   r_pend_din;
    logic [MEM_AW-1:0]   r_addr;
    logic [DATA_W-1:0]   r_din;
    logic [DATA_W-1:0]   r_dout;
    logic                r_err;

    state_t              w_state_nxt;
    logic [CNT_W-1:0]    w_cnt_nxt;
    logic                w_rd_edge;
    logic                w_wr_edge;
    logic                w_take;
    logic                w_take_wr;
    logic [MEM_AW-1:0]   w_take_addr;
    logic [DATA_W-1:0]   w_take_din;
    logic                w_pend_pop;
    logic                w_to_pend;
    logic                w_pend_load;
    logic                w_collide;
    logic                w_overrun;
    logic                w_rd_done;
    logic                w_commit_wr;
    logic [DATA_W-1:0]   w_bram_q;
    logic                w_unused_addr;

    // Address bits above MEM_AW alias onto the same BRAM words.
    assign w_unused_addr = ^ch_addr[CH_AW-1:MEM_AW];

    // A level already high when reset releases is not an edge: rd_q/wr_q
    // reset to 1.
    assign w_rd_edge = ch_rd & ~r_rd_q;
    assign w_wr_edge = ch_wr & ~r_wr_q;
    assign w_collide = w_rd_edge & w_wr_edge;

    // A new edge is served directly only from IDLE with nothing pending;
    // otherwise it goes to the 1-deep pend slot, or is dropped if full.
    assign w_to_pend   = (w_rd_edge | w_wr_edge) &
                         ~((r_state == ST_IDLE) & ~r_pend_vld);
    assign w_pend_load = w_to_pend & ~r_pend_vld;
    assign w_overrun   = w_to_pend & r_pend_vld;

    assign w_rd_done   = (r_state == ST_RD_WAIT) && (r_cnt == '0);
    // Reset during the final write cycle still suppresses the commit.
    assign w_commit_wr = (r_state == ST_WR_WAIT) && (r_cnt == '0) && !reset;

    // NOTE: every signal written here gets a default first, so no path
    // through the case leaves one unassigned and no latch is inferred.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_take      = 1'b0;
        w_take_wr   = 1'b0;
        w_take_addr = r_addr;
        w_take_din  = r_din;
        w_pend_pop  = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (r_pend_vld) begin
                    w_take      = 1'b1;
                    w_take_wr   = r_pend_wr;
                    w_take_addr = r_pend_addr;
                    w_take_din  = r_pend_din;
                    w_pend_pop  = 1'b1;
                end else if (w_wr_edge) begin
                    w_take      = 1'b1;
                    w_take_wr   = 1'b1;
                    w_take_addr = ch_addr[MEM_AW-1:0];
                    w_take_din  = ch_din;
                end else if (w_rd_edge) begin
                    w_take      = 1'b1;
                    w_take_addr = ch_addr[MEM_AW-1:0];
                end else if (refresh) begin
                    w_state_nxt = ST_REFRESH;
                    w_cnt_nxt   = REF_CNT;
                end

                if (w_take) begin
                    w_state_nxt = w_take_wr ? ST_WR_WAIT : ST_RD_WAIT;
                    w_cnt_nxt   = w_take_wr ? WR_CNT : RD_CNT;
                end
            end
            default: begin
                if (r_cnt == '0) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_rd_q     <= 1'b1;
            r_wr_q     <= 1'b1;
            r_pend_vld <= 1'b0;
            r_dout     <= '0;
            r_err      <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_rd_q  <= ch_rd;
            r_wr_q  <= ch_wr;
            if (w_pend_pop) begin
                r_pend_vld <= 1'b0;
            end
            if (w_pend_load) begin
                r_pend_vld <= 1'b1;
            end
            if (w_rd_done) begin
                r_dout <= w_bram_q;
            end
            if (w_collide || w_overrun) begin
                r_err <= 1'b1;
            end
        end
    end

    // Datapath captures; their contents matter only while the matching
    // state or valid flag says so.
    always_ff @(posedge clk_sys) begin
        if (w_take) begin
            r_addr <= w_take_addr;
            r_din  <= w_take_din;
        end
        if (w_pend_load) begin
            r_pend_wr   <= w_wr_edge;
            r_pend_addr <= ch_addr[MEM_AW-1:0];
            r_pend_din  <= ch_din;
        end
    end

    // Read address is held from the first RD_WAIT cycle, so the registered
    // BRAM output is settled well before the final cycle loads ch_dout.
    ch_bram_responder_bram_sp #(
        .AW (MEM_AW),
        .DW (DATA_W)
    ) u_bram (
        .i_clk  (clk_sys),
        .i_we   (w_commit_wr),
        .i_addr (r_addr),
        .i_din  (r_din),
        .o_q    (w_bram_q)
    );

    assign ch_busy    = (r_state != ST_IDLE) | w_rd_edge | w_wr_edge | r_pend_vld;
    assign ch_dout    = r_dout;
    assign ch_err     = r_err;
    assign test_state = r_state;

endmodule

// File: tb/tb_ch_bram_responder.sv
// ---------------------------------------------------------------------------
// tb_ch_bram_responder
// Self-checking bench for ch_bram_responder. A transaction-level model keeps
// the memory image and the last read value; busy lengths are predicted from
// the rule that every request occupies (latency + 1) busy cycles, served
// back to back.
// ---------------------------------------------------------------------------
module tb_ch_bram_responder;

    localparam int RD_LAT  = 4;
    localparam int WR_LAT  = 3;
    localparam int REF_CYC = 6;

    logic        clk_sys = 1'b0;
    logic        reset;
    logic [24:0] ch_addr;
    logic        ch_wr;
    logic [7:0]  ch_din;
    logic        ch_rd;
    logic [7:0]  ch_dout;
    logic        ch_busy;
    logic        refresh;
    logic        ch_err;
    logic [1:0]  test_state;

    always #5 clk_sys = ~clk_sys;

    ch_bram_responder #(
        .MEM_AW         (14),
        .DATA_W         (8),
        .RD_LATENCY     (RD_LAT),
        .WR_LATENCY     (WR_LAT),
        .REFRESH_CYCLES (REF_CYC)
    ) dut (
        .clk_sys    (clk_sys),
        .reset      (reset),
        .ch_addr    (ch_addr),
        .ch_wr      (ch_wr),
        .ch_din     (ch_din),
        .ch_rd      (ch_rd),
        .ch_dout    (ch_dout),
        .ch_busy    (ch_busy),
        .refresh    (refresh),
        .ch_err     (ch_err),
        .test_state (test_state)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: memory image and last value returned by a read.
    logic [7:0] m_mem [0:16383];
    logic [7:0] m_dout;
    logic [13:0] pool[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic m_apply(input bit wr, input logic [24:0] a, input logic [7:0] d);
        if (wr) m_mem[a[13:0]] = d;
        else    m_dout = m_mem[a[13:0]];
    endtask

    // Issue request A (optionally rd+wr together), optionally request B at
    // cycle offset b_at, then count busy cycles until busy first falls and
    // check that count and the read data against the model.
    task automatic run_seq(input string tag,
                           input bit a_wr, input bit a_both,
                           input logic [24:0] a_addr, input logic [7:0] a_din,
                           input bit has_b, input bit b_wr,
                           input logic [24:0] b_addr, input logic [7:0] b_din,
                           input int b_at, input int extra_exp);
        int n;
        int exp_n;
        bit done;
        @(negedge clk_sys);
        ch_addr = a_addr;
        ch_din  = a_din;
        ch_wr   = a_wr | a_both;
        ch_rd   = !a_wr | a_both;
        n = 0;
        done = 1'b0;
        for (int k = 0; k < 64 && !done; k++) begin
            #1;
            if (ch_busy) n++;
            else done = 1'b1;
            if (!done) begin
                @(negedge clk_sys);
                ch_rd = 1'b0;
                ch_wr = 1'b0;
                if (has_b && (k + 1 == b_at)) begin
                    ch_addr = b_addr;
                    ch_din  = b_din;
                    ch_wr   = b_wr;
                    ch_rd   = !b_wr;
                end
            end
        end
        ch_rd = 1'b0;
        ch_wr = 1'b0;
        check({tag, "_done"}, 32'(done), 32'd1);
        exp_n = ((a_wr | a_both) ? WR_LAT : RD_LAT) + 1 + extra_exp;
        if (has_b) exp_n += (b_wr ? WR_LAT : RD_LAT) + 1;
        check({tag, "_busy_len"}, 32'(n), 32'(exp_n));
        m_apply(a_wr | a_both, a_addr, a_din);
        if (has_b) m_apply(b_wr, b_addr, b_din);
        check({tag, "_dout"}, 32'(ch_dout), 32'(m_dout));
    endtask

    initial begin
        int n_ref;
        reset   = 1'b1;
        ch_addr = '0;
        ch_wr   = 1'b0;
        ch_din  = '0;
        ch_rd   = 1'b1;
        refresh = 1'b0;
        m_dout  = '0;

        // 1: ch_rd held high across reset release is not a request.
        repeat (3) @(negedge clk_sys);
        reset = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #1;
            check("t1_busy", 32'(ch_busy), 32'd0);
            check("t1_state", 32'(test_state), 32'd0);
            @(negedge clk_sys);
        end
        #1;
        check("t1_dout", 32'(ch_dout), 32'd0);
        check("t1_err", 32'(ch_err), 32'd0);
        ch_rd = 1'b0;
        #1;
        check("t1_busy_fall", 32'(ch_busy), 32'd0);

        // 2: write then read the screen base + 5.
        run_seq("t2_wr", 1, 0, 25'h2005, 8'h41, 0, 0, '0, '0, 0, 0);
        run_seq("t2_rd", 0, 0, 25'h2005, 8'h00, 0, 0, '0, '0, 0, 0);
        check("t2_data", 32'(ch_dout), 32'h41);

        // 3: address aliasing above MEM_AW.
        run_seq("t3_wr", 1, 0, 25'h6005, 8'h55, 0, 0, '0, '0, 0, 0);
        run_seq("t3_rd", 0, 0, 25'h2005, 8'h00, 0, 0, '0, '0, 0, 0);
        check("t3_err", 32'(ch_err), 32'd0);

        // 4: one-cycle refresh pulse, read edge two cycles later.
        @(negedge clk_sys);
        refresh = 1'b1;
        #1;
        check("t4_busy_pulse", 32'(ch_busy), 32'd0);
        @(negedge clk_sys);
        refresh = 1'b0;
        #1;
        n_ref = ch_busy ? 1 : 0;
        check("t4_busy_ref", 32'(n_ref), 32'd1);
        check("t4_state_ref", 32'(test_state), 32'd3);
        // Refresh covers the read's cycle and the REF_CYC-2 after it.
        run_seq("t4_rd", 0, 0, 25'h2005, 8'h00, 0, 0, '0, '0, 0, REF_CYC - 1);
        check("t4_data", 32'(ch_dout), 32'h55);

        // 5: simultaneous rd and wr edges: write wins, error flagged.
        run_seq("t5_both", 1, 1, 25'h0010, 8'h7E, 0, 0, '0, '0, 0, 0);
        check("t5_err", 32'(ch_err), 32'd1);
        run_seq("t5_rd", 0, 0, 25'h0010, 8'h00, 0, 0, '0, '0, 0, 0);
        check("t5_data", 32'(ch_dout), 32'h7E);

        // 6: reset during the second WR_WAIT cycle aborts the write.
        run_seq("t6_wr_old", 1, 0, 25'h0020, 8'h11, 0, 0, '0, '0, 0, 0);
        @(negedge clk_sys);
        ch_addr = 25'h0020;
        ch_din  = 8'hAA;
        ch_wr   = 1'b1;
        @(negedge clk_sys);
        ch_wr = 1'b0;
        #1;
        check("t6_state_wr", 32'(test_state), 32'd2);
        @(negedge clk_sys);
        reset = 1'b1;
        @(negedge clk_sys);
        reset = 1'b0;
        m_dout = '0;
        #1;
        check("t6_state_rst", 32'(test_state), 32'd0);
        check("t6_err_rst", 32'(ch_err), 32'd0);
        check("t6_dout_rst", 32'(ch_dout), 32'd0);
        run_seq("t6_rd", 0, 0, 25'h0020, 8'h00, 0, 0, '0, '0, 0, 0);
        check("t6_data", 32'(ch_dout), 32'h11);

        // Randomized traffic, single and back-to-back (pended) requests.
        for (int it = 0; it < 40; it++) begin
            bit          a_wr;
            bit          has_b;
            bit          b_wr;
            logic [13:0] a_idx;
            logic [13:0] b_idx;
            logic [7:0]  a_d;
            logic [7:0]  b_d;
            int          b_at;
            string       tag;
            a_wr = (pool.size() == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            if (a_wr) begin
                a_idx = 14'($urandom_range(0, 63)) | ($urandom_range(0, 1) ? 14'h2000 : 14'h0000);
                pool.push_back(a_idx);
            end else begin
                a_idx = pool[$urandom_range(0, pool.size() - 1)];
            end
            a_d   = 8'($urandom);
            has_b = 1'($urandom_range(0, 1));
            b_wr  = 1'($urandom_range(0, 1));
            if (b_wr) begin
                b_idx = 14'($urandom_range(0, 63));
            end else begin
                b_idx = pool[$urandom_range(0, pool.size() - 1)];
            end
            b_d  = 8'($urandom);
            b_at = $urandom_range(2, a_wr ? WR_LAT : RD_LAT);
            tag  = $sformatf("rnd%0d", it);
            run_seq(tag, a_wr, 0, {11'($urandom), a_idx}, a_d,
                    has_b, b_wr, {11'($urandom), b_idx}, b_d, b_at, 0);
            if (has_b && b_wr) pool.push_back(b_idx);
            repeat ($urandom_range(0, 3)) @(negedge clk_sys);
        end
        #1;
        check("rnd_err", 32'(ch_err), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
